// File: rtl/brt_usb_ss_link_channel.sv
// SuperSpeed link channel model: per-direction, per-lane sampled delay lines,
// electrical-idle detection on the receive outputs, and registered termination
// paths. Define BRT_USB_SS_LINK_ERR_INJ_EN to build lane-0 bit-error injection
// (p/m swap). Without it, samples always pass unmodified and err_cnt is 0.
module brt_usb_ss_link_channel #(
  parameter int NUM_LANES = 1,
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = $clog2(MAX_DELAY),
  parameter int IDLE_CYC  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] sstxp_host,
  input  logic [NUM_LANES-1:0] sstxm_host,
  output logic [NUM_LANES-1:0] ssrxp_device,
  output logic [NUM_LANES-1:0] ssrxm_device,
  input  logic [NUM_LANES-1:0] sstxp_device,
  input  logic [NUM_LANES-1:0] sstxm_device,
  output logic [NUM_LANES-1:0] ssrxp_host,
  output logic [NUM_LANES-1:0] ssrxm_host,
  input  logic                 vip_ss_termination_host,
  output logic                 dut_ss_termination_device,
  input  logic                 vip_ss_termination_device,
  output logic                 dut_ss_termination_host,
  input  logic [DLY_W-1:0]     dly_h2d,
  input  logic [DLY_W-1:0]     dly_d2h,
  output logic                 eidle_h2d,
  output logic                 eidle_d2h,
  input  logic                 err_inj_en,
  input  logic                 err_dir,
  input  logic [15:0]          err_period,
  output logic [15:0]          err_cnt
);

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC);

  // Direction index 0 = host->device, 1 = device->host.
  logic [NUM_LANES-1:0]                  tx_p   [2];
  logic [NUM_LANES-1:0]                  tx_m   [2];
  logic [NUM_LANES-1:0]                  in_p   [2];
  logic [NUM_LANES-1:0]                  in_m   [2];
  logic [MAX_DELAY-1:0][NUM_LANES-1:0]   tap_p  [2];
  logic [MAX_DELAY-1:0][NUM_LANES-1:0]   tap_m  [2];
  logic [MAX_DELAY-2:0][NUM_LANES-1:0]   line_p [2];
  logic [MAX_DELAY-2:0][NUM_LANES-1:0]   line_m [2];
  logic [NUM_LANES-1:0]                  rx_p   [2];
  logic [NUM_LANES-1:0]                  rx_m   [2];
  logic [DLY_W-1:0]                      dly    [2];
  logic [7:0]                            idle_cnt [2];
  logic [1:0]                            swap;

`ifdef BRT_USB_SS_LINK_ERR_INJ_EN
  logic [15:0] phase;
  logic        dir_q;
  logic        sel_act;
  logic        inj_active;
  logic        inj_hit;

  // Decide whether the lane-0 sample entering the selected line is swapped.
  always_comb begin
    sel_act    = err_dir ? (sstxp_device[0] != sstxm_device[0])
                         : (sstxp_host[0]   != sstxm_host[0]);
    inj_active = err_inj_en && (err_period != '0) && (err_dir == dir_q);
    inj_hit    = inj_active && sel_act && (phase == err_period - 16'd1);
    swap          = '0;
    swap[err_dir] = inj_hit;
  end

  // Phase counter over active lane-0 samples, plus saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      dir_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      dir_q <= err_dir;
      // inj_active is low on disable, zero period, or a direction change.
      if (!inj_active)  phase <= '0;
      else if (inj_hit) phase <= '0;
      else if (sel_act) phase <= phase + 16'd1;
      if (inj_hit && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_inj;

  assign unused_inj = ^{err_inj_en, err_dir, err_period};
  assign swap       = '0;
  assign err_cnt    = '0;
`endif

  // Gather per-direction inputs, apply swap, build the tap vector (tap 0 = live input).
  always_comb begin
    tx_p[0] = sstxp_host;
    tx_m[0] = sstxm_host;
    tx_p[1] = sstxp_device;
    tx_m[1] = sstxm_device;
    dly[0]  = dly_h2d;
    dly[1]  = dly_d2h;
    for (int unsigned d = 0; d < 2; d++) begin
      in_p[d] = tx_p[d];
      in_m[d] = tx_m[d];
      if (swap[d]) begin
        in_p[d][0] = tx_m[d][0];
        in_m[d][0] = tx_p[d][0];
      end
      tap_p[d] = {line_p[d], in_p[d]};
      tap_m[d] = {line_m[d], in_m[d]};
    end
  end

  // Delay lines, registered tap select and electrical-idle run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < 2; d++) begin
        line_p[d]   <= '0;
        line_m[d]   <= '0;
        rx_p[d]     <= '0;
        rx_m[d]     <= '0;
        idle_cnt[d] <= IDLE_MAX;
      end
    end else begin
      for (int unsigned d = 0; d < 2; d++) begin
        line_p[d] <= tap_p[d][MAX_DELAY-2:0];
        line_m[d] <= tap_m[d][MAX_DELAY-2:0];
        rx_p[d]   <= tap_p[d][dly[d]];
        rx_m[d]   <= tap_m[d][dly[d]];
        if (rx_p[d] != rx_m[d])         idle_cnt[d] <= '0;
        else if (idle_cnt[d] != IDLE_MAX) idle_cnt[d] <= idle_cnt[d] + 8'd1;
      end
    end
  end

  // Termination presence crosses through one flop each way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_ss_termination_device <= 1'b0;
      dut_ss_termination_host   <= 1'b0;
    end else begin
      dut_ss_termination_device <= vip_ss_termination_host;
      dut_ss_termination_host   <= vip_ss_termination_device;
    end
  end

  assign ssrxp_device = rx_p[0];
  assign ssrxm_device = rx_m[0];
  assign ssrxp_host   = rx_p[1];
  assign ssrxm_host   = rx_m[1];
  assign eidle_h2d    = (idle_cnt[0] == IDLE_MAX);
  assign eidle_d2h    = (idle_cnt[1] == IDLE_MAX);

endmodule

// File: tb/tb_brt_usb_ss_link_channel.sv
// Directed bench for brt_usb_ss_link_channel (2 lanes, depth 16, idle run 8).
// Expectations follow BRT_USB_SS_LINK_ERR_INJ_EN when it is defined for the build.
module tb_brt_usb_ss_link_channel;

`ifdef BRT_USB_SS_LINK_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sstxp_host, sstxm_host, ssrxp_device, ssrxm_device;
  logic [1:0] sstxp_device, sstxm_device, ssrxp_host, ssrxm_host;
  logic       vip_ss_termination_host, dut_ss_termination_device;
  logic       vip_ss_termination_device, dut_ss_termination_host;
  logic [3:0] dly_h2d, dly_d2h;
  logic       eidle_h2d, eidle_d2h;
  logic       err_inj_en, err_dir;
  logic [15:0] err_period, err_cnt;

  int tests = 0;
  int fails = 0;

  logic [3:0] s_h [40];
  logic [3:0] s_d [40];
  logic [1:0] p, m, p2, m2;
  logic [3:0] exp_h;
  bit         sw, en;

  brt_usb_ss_link_channel #(
    .NUM_LANES(2),
    .MAX_DELAY(16),
    .IDLE_CYC (8)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .sstxp_host                (sstxp_host),
    .sstxm_host                (sstxm_host),
    .ssrxp_device              (ssrxp_device),
    .ssrxm_device              (ssrxm_device),
    .sstxp_device              (sstxp_device),
    .sstxm_device              (sstxm_device),
    .ssrxp_host                (ssrxp_host),
    .ssrxm_host                (ssrxm_host),
    .vip_ss_termination_host   (vip_ss_termination_host),
    .dut_ss_termination_device (dut_ss_termination_device),
    .vip_ss_termination_device (vip_ss_termination_device),
    .dut_ss_termination_host   (dut_ss_termination_host),
    .dly_h2d                   (dly_h2d),
    .dly_d2h                   (dly_d2h),
    .eidle_h2d                 (eidle_h2d),
    .eidle_d2h                 (eidle_d2h),
    .err_inj_en                (err_inj_en),
    .err_dir                   (err_dir),
    .err_period                (err_period),
    .err_cnt                   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sstxp_host = '0; sstxm_host = '0; sstxp_device = '0; sstxm_device = '0;
    vip_ss_termination_host = 1'b0; vip_ss_termination_device = 1'b0;
    dly_h2d = '0; dly_d2h = '0;
    err_inj_en = 1'b0; err_dir = 1'b0; err_period = 16'd4;

    // Reset held with toggling traffic
    for (int i = 0; i < 4; i++) begin
      sstxp_host = 2'(i); sstxm_host = ~2'(i);
      sstxp_device = ~2'(i); sstxm_device = 2'(i);
      tick();
    end
    check("rst_rx_dev", {28'd0, ssrxp_device, ssrxm_device}, 32'd0);
    check("rst_rx_host", {28'd0, ssrxp_host, ssrxm_host}, 32'd0);
    check("rst_eidle", {30'd0, eidle_h2d, eidle_d2h}, 32'd3);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_term", {30'd0, dut_ss_termination_device, dut_ss_termination_host}, 32'd0);

    // Release, first sample 1/0 at dly 0
    sstxp_host = '0; sstxm_host = '0; sstxp_device = '0; sstxm_device = '0;
    rst_n = 1'b1;
    #2;
    check("post_rst_rx", {28'd0, ssrxp_device, ssrxm_device}, 32'd0);
    sstxp_host = 2'b01; sstxm_host = 2'b00;
    tick();
    check("first_p", {30'd0, ssrxp_device}, 32'd1);
    check("first_m", {30'd0, ssrxm_device}, 32'd0);

    // Delay sweep: h2d latency 6, d2h latency 16
    dly_h2d = 4'd5; dly_d2h = 4'd15;
    sstxp_host = '0; sstxm_host = '0; sstxp_device = '0; sstxm_device = '0;
    for (int i = 0; i < 17; i++) tick();
    for (int i = 0; i < 40; i++) begin
      p = 2'($urandom_range(0, 3)); p2 = 2'($urandom_range(0, 3));
      s_h[i] = {p, ~p};
      s_d[i] = {p2, ~p2};
      sstxp_host = p;  sstxm_host = ~p;
      sstxp_device = p2; sstxm_device = ~p2;
      tick();
      if (i >= 5)  check("dly_h2d", {28'd0, ssrxp_device, ssrxm_device}, {28'd0, s_h[i-5]});
      if (i >= 15) check("dly_d2h", {28'd0, ssrxp_host, ssrxm_host}, {28'd0, s_d[i-15]});
    end

    // Electrical idle
    dly_h2d = '0; dly_d2h = '0;
    sstxp_host = '0; sstxm_host = '0; sstxp_device = '0; sstxm_device = '0;
    for (int i = 0; i < 20; i++) tick();
    check("eidle_h2d_idle", {31'd0, eidle_h2d}, 32'd1);
    check("eidle_d2h_idle", {31'd0, eidle_d2h}, 32'd1);
    sstxp_host = 2'b01; sstxm_host = 2'b10;
    tick();
    check("eidle_e0", {31'd0, eidle_h2d}, 32'd1);
    tick();
    check("eidle_e1", {31'd0, eidle_h2d}, 32'd0);
    tick();
    sstxp_host = '0; sstxm_host = '0;
    for (int k = 3; k <= 11; k++) begin
      tick();
      check("eidle_tail", {31'd0, eidle_h2d}, (k == 11) ? 32'd1 : 32'd0);
    end
    check("eidle_d2h_quiet", {31'd0, eidle_d2h}, 32'd1);

    // Error injection, period 4, host->device
    err_inj_en = 1'b1; err_dir = 1'b0; err_period = 16'd4;
    for (int i = 0; i < 40; i++) begin
      p = 2'($urandom_range(0, 3)); p2 = 2'($urandom_range(0, 3));
      m = ~p; m2 = ~p2;
      sstxp_host = p; sstxm_host = m; sstxp_device = p2; sstxm_device = m2;
      sw = INJ && ((i % 4) == 3);
      exp_h = sw ? {p[1], m[0], m[1], p[0]} : {p, m};
      tick();
      check("inj_h2d", {28'd0, ssrxp_device, ssrxm_device}, {28'd0, exp_h});
      check("inj_d2h", {28'd0, ssrxp_host, ssrxm_host}, {28'd0, p2, m2});
    end
    check("inj_err_cnt", {16'd0, err_cnt}, INJ ? 32'd10 : 32'd0);

    // Disable mid-stream then re-enable: swaps at 3, 12, 16
    for (int j = 0; j < 17; j++) begin
      en = !(j >= 6 && j < 9);
      err_inj_en = en;
      p = 2'($urandom_range(0, 3)); m = ~p;
      sstxp_host = p; sstxm_host = m;
      sw = INJ && (j == 3 || j == 12 || j == 16);
      exp_h = sw ? {p[1], m[0], m[1], p[0]} : {p, m};
      tick();
      check("dis_h2d", {28'd0, ssrxp_device, ssrxm_device}, {28'd0, exp_h});
    end
    check("dis_err_cnt", {16'd0, err_cnt}, INJ ? 32'd13 : 32'd0);
    err_inj_en = 1'b0;

    // Terminations
    vip_ss_termination_host = 1'b1;
    #1;
    check("term_h_pre", {31'd0, dut_ss_termination_device}, 32'd0);
    tick();
    check("term_h_rise", {31'd0, dut_ss_termination_device}, 32'd1);
    vip_ss_termination_host = 1'b0;
    vip_ss_termination_device = 1'b1;
    tick();
    check("term_h_fall", {31'd0, dut_ss_termination_device}, 32'd0);
    check("term_d_rise", {31'd0, dut_ss_termination_host}, 32'd1);
    vip_ss_termination_host = 1'b1;
    tick();
    check("term_h_high", {31'd0, dut_ss_termination_device}, 32'd1);

    // Asynchronous reset mid-cycle with traffic active
    sstxp_host = 2'b11; sstxm_host = 2'b00;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_term", {30'd0, dut_ss_termination_device, dut_ss_termination_host}, 32'd0);
    check("arst_rx", {28'd0, ssrxp_device, ssrxm_device}, 32'd0);
    check("arst_eidle", {30'd0, eidle_h2d, eidle_d2h}, 32'd3);
    check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
    #2;
    rst_n = 1'b1;
    sstxp_host = '0; sstxm_host = '0;
    dly_h2d = 4'd3;
    tick();
    sstxp_host = 2'b10; sstxm_host = 2'b01;
    tick();
    check("arst_flushed", {28'd0, ssrxp_device, ssrxm_device}, 32'd0);
    sstxp_host = '0; sstxm_host = '0;
    tick(); tick(); tick();
    check("arst_new_sample", {28'd0, ssrxp_device, ssrxm_device}, 32'h9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
